apb_irq_ctrl: RTL and testbench
===============================

// Module: apb_irq_ctrl
// PURPOSE
//  Parametrised APB interrupt controller: collects NUM_IRQ external sources plus one
//  non-maskable source, latches them per-source as level or rising-edge, masks, and
//  raises a single registered cpu_interrupt. Sits on the APB bus beside the timer and
//  adds per-source mode control, a claim register and reset.
// PARAMETERS
//  ADDR_WIDTH  32            APB address width
//  DATA_WIDTH  32            APB data width (fixed at 32 for register layout)
//  NUM_IRQ     8             maskable sources, legal 1..31 (bit 31 reserved for NMI)
//  BASE_ADDR   'h20000000    register window base
// PORTS
//  pclk           in   1           clock, all logic on rising edge
//  presetn        in   1           asynchronous active-low reset
//  paddr          in   ADDR_WIDTH  APB address
//  pdata          in   DATA_WIDTH  APB write data
//  prdata         out  DATA_WIDTH  APB read data, registered
//  psel/penable   in   1           APB select / enable
//  pwrite         in   1           1 = write
//  pstb           in   4           byte strobes for writes
//  pready         out  1           one-cycle transfer complete
//  perr           out  1           slave error, valid with pready
//  irq_in         in   NUM_IRQ     asynchronous interrupt sources
//  nmi_in         in   1           non-maskable source (bus error etc.)
//  cpu_interrupt  out  1           registered interrupt request to CPU
// BEHAVIOUR
//  Reset: prdata=0, pready=0, perr=0, cpu_interrupt=0; PENDING/MASK/MODE=0, sync flops=0.
//  Registers (BASE_ADDR+): 0x00 PENDING (R, W1C); 0x04 MASK (RW); 0x08 MODE (RW,
//   1=edge 0=level); 0x0C CLAIM (RO); 0x10 RAW (RO). Bits >= NUM_IRQ read 0, ignore writes
//   except PENDING[31]=NMI sticky bit.
//  Inputs: irq_in and nmi_in pass 2-flop synchroniser; edge detect compares sync output
//   with one further delayed copy. Rising edge at irq_in -> PENDING set 3 clocks later.
//  Level source: PENDING[i] = synced level each cycle; W1C has no effect.
//  Edge source: PENDING[i] set on rising edge, cleared by W1C; same-cycle set and clear
//   -> set wins. MODE bit written 0->1 clears PENDING[i] that cycle.
//  NMI: PENDING[31] set on synced nmi_in high (sticky), W1C clears, set wins; not maskable.
//  cpu_interrupt <= |(PENDING[NUM_IRQ-1:0] & MASK) | PENDING[31]; one cycle after PENDING.
//  CLAIM: bit31 = any masked-pending, bits[4:0] = lowest index i with PENDING&MASK; else 0.
//   Read has no side effect. RAW returns synced levels.
//  APB: setup (psel,!penable) then access; at first edge with psel&penable&!pready:
//   pready<=1 for exactly one cycle, write committed, prdata captured; pready drops next
//   cycle even if penable held. Back-to-back transfers need a new setup phase.
//  pstb[k] gates byte k for MASK, MODE and PENDING W1C writes; pstb=0 -> no change.
//  perr=1 with pready for unmapped offset or write to CLAIM/RAW; no state change, prdata=0.
//  Reads of unmapped offsets return 0. prdata holds last value between transfers.
//  presetn low mid-transfer: all state clears asynchronously; pending APB access dropped,
//   pready=0 until a fresh access after release.
// TESTING
//  Reset, read all regs -> 0; cpu_interrupt=0, pready pulses 1 cycle per access, perr=0.
//  MASK=0x01, MODE=0x01, pulse irq_in[0] 1 cycle -> PENDING=0x1 at +3, cpu_interrupt=1
//   at +4; write PENDING 0x1 -> PENDING=0, cpu_interrupt=0 next cycle.
//  MODE=0, MASK=0x0C, irq_in[3:2]=2'b11 held -> CLAIM=0x80000002; W1C ignored;
//   drop irq_in[2] -> CLAIM=0x80000003; drop all -> CLAIM=0.
//  MASK=0, nmi_in pulse -> PENDING[31]=1, cpu_interrupt=1; W1C 0x80000000 on same cycle
//   as new nmi edge -> bit stays 1.
//  Write MASK=0xFFFF with pstb=4'b0001 -> MASK=0x00FF; write CLAIM or offset 0x1C ->
//   perr=1, no register change.
//  Assert presetn low during access phase -> pready/cpu_interrupt/regs 0 immediately.

Source files
------------

// File: rtl/apb_irq_ctrl_if.sv
// APB slave bus bundle for the interrupt controller: address/data, handshake and
// byte strobes, with master and slave views.
interface apb_irq_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   paddr;
    logic [DATA_WIDTH-1:0]   pdata;
    logic [DATA_WIDTH-1:0]   prdata;
    logic                    psel;
    logic                    penable;
    logic                    pwrite;
    logic [DATA_WIDTH/8-1:0] pstb;
    logic                    pready;
    logic                    perr;

    modport master (
        output paddr, pdata, psel, penable, pwrite, pstb,
        input  prdata, pready, perr
    );

    modport slave (
        input  paddr, pdata, psel, penable, pwrite, pstb,
        output prdata, pready, perr
    );
endinterface

// File: rtl/apb_irq_ctrl.sv
// APB interrupt controller: synchronised level/edge sources plus sticky NMI,
// masked into one registered cpu_interrupt, with PENDING/MASK/MODE/CLAIM/RAW registers.
module apb_irq_ctrl #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           NUM_IRQ    = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 'h20000000
) (
    input  logic               pclk,
    input  logic               presetn,
    apb_irq_ctrl_if.slave      bus,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               nmi_in,
    output logic               cpu_interrupt
);
    localparam int unsigned NMI_BIT = 31;
    localparam logic [DATA_WIDTH-1:0] IRQ_BITS =
        DATA_WIDTH'((64'd1 << NUM_IRQ) - 64'd1);

    localparam logic [ADDR_WIDTH-1:0] OFF_PENDING = ADDR_WIDTH'(8'h00);
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK    = ADDR_WIDTH'(8'h04);
    localparam logic [ADDR_WIDTH-1:0] OFF_MODE    = ADDR_WIDTH'(8'h08);
    localparam logic [ADDR_WIDTH-1:0] OFF_CLAIM   = ADDR_WIDTH'(8'h0C);
    localparam logic [ADDR_WIDTH-1:0] OFF_RAW     = ADDR_WIDTH'(8'h10);

    logic [NUM_IRQ-1:0]    irq_s1_q, irq_s2_q, irq_s3_q;
    logic                  nmi_s1_q, nmi_s2_q;

    logic [DATA_WIDTH-1:0] pending_q, pending_d;
    logic [DATA_WIDTH-1:0] mask_q, mask_d;
    logic [DATA_WIDTH-1:0] mode_q, mode_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
    logic                  pready_q, pready_d;
    logic                  perr_q, perr_d;
    logic                  setup_q, setup_d;
    logic                  cpu_q, cpu_d;

    logic [ADDR_WIDTH-1:0] offset;
    logic                  sel_pend, sel_mask, sel_mode, sel_claim, sel_raw;
    logic                  bus_err, access, wr_ok;
    logic [DATA_WIDTH-1:0] byte_mask, wbits, clr;
    logic [DATA_WIDTH-1:0] irq_lvl, irq_rise, active, edge_next, mode_rise;
    logic [DATA_WIDTH-1:0] claim, rdata;
    logic                  claim_found;
    logic [4:0]            claim_idx;

    // Two-flop synchroniser plus one delayed copy for rising-edge detection.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            irq_s1_q <= '0;
            irq_s2_q <= '0;
            irq_s3_q <= '0;
            nmi_s1_q <= 1'b0;
            nmi_s2_q <= 1'b0;
        end else begin
            irq_s1_q <= irq_in;
            irq_s2_q <= irq_s1_q;
            irq_s3_q <= irq_s2_q;
            nmi_s1_q <= nmi_in;
            nmi_s2_q <= nmi_s1_q;
        end
    end

    assign irq_lvl  = DATA_WIDTH'(irq_s2_q);
    assign irq_rise = DATA_WIDTH'(irq_s2_q & ~irq_s3_q);
    assign active   = pending_q & mask_q & IRQ_BITS;

    always_comb begin
        offset    = bus.paddr - BASE_ADDR;
        sel_pend  = (offset == OFF_PENDING);
        sel_mask  = (offset == OFF_MASK);
        sel_mode  = (offset == OFF_MODE);
        sel_claim = (offset == OFF_CLAIM);
        sel_raw   = (offset == OFF_RAW);
        bus_err   = !(sel_pend | sel_mask | sel_mode | sel_claim | sel_raw)
                  | (bus.pwrite & (sel_claim | sel_raw));
    end

    // A transfer completes only once per setup phase; a held penable cannot re-trigger.
    assign access = bus.psel & bus.penable & setup_q & ~pready_q;
    assign wr_ok  = access & bus.pwrite & ~bus_err;

    always_comb begin
        for (int unsigned k = 0; k < DATA_WIDTH / 8; k++) begin
            byte_mask[8*k +: 8] = {8{bus.pstb[k]}};
        end
    end
    assign wbits = bus.pdata & byte_mask;

    always_comb begin
        claim_found = 1'b0;
        claim_idx   = '0;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            if (active[i] && !claim_found) begin
                claim_found = 1'b1;
                claim_idx   = 5'(i);
            end
        end
        claim          = '0;
        claim[NMI_BIT] = claim_found;
        claim[4:0]     = claim_idx;
    end

    always_comb begin
        rdata = '0;
        if (sel_pend)  rdata = pending_q;
        if (sel_mask)  rdata = mask_q;
        if (sel_mode)  rdata = mode_q;
        if (sel_claim) rdata = claim;
        if (sel_raw)   rdata = irq_lvl;
    end

    always_comb begin
        mask_d = mask_q;
        mode_d = mode_q;
        clr    = '0;
        if (wr_ok && sel_mask) mask_d = ((mask_q & ~byte_mask) | wbits) & IRQ_BITS;
        if (wr_ok && sel_mode) mode_d = ((mode_q & ~byte_mask) | wbits) & IRQ_BITS;
        if (wr_ok && sel_pend) clr    = wbits;
    end

    // Level bits follow the synced input; edge bits latch until W1C, with a new edge
    // beating a same-cycle clear; switching a bit into edge mode discards its state.
    always_comb begin
        mode_rise          = mode_d & ~mode_q;
        edge_next          = (pending_q & ~clr) | irq_rise;
        pending_d          = ((mode_q & edge_next) | (~mode_q & irq_lvl))
                           & ~mode_rise & IRQ_BITS;
        pending_d[NMI_BIT] = (pending_q[NMI_BIT] & ~clr[NMI_BIT]) | nmi_s2_q;
    end

    assign cpu_d = (|active) | pending_q[NMI_BIT];

    always_comb begin
        setup_d  = setup_q;
        pready_d = 1'b0;
        perr_d   = perr_q;
        prdata_d = prdata_q;
        if (access) begin
            setup_d  = 1'b0;
            pready_d = 1'b1;
            perr_d   = bus_err;
            if (bus_err)          prdata_d = '0;
            else if (!bus.pwrite) prdata_d = rdata;
        end else if (bus.psel && !bus.penable) begin
            setup_d = 1'b1;
        end else if (!bus.psel) begin
            setup_d = 1'b0;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            pending_q <= '0;
            mask_q    <= '0;
            mode_q    <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            perr_q    <= 1'b0;
            setup_q   <= 1'b0;
            cpu_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            mask_q    <= mask_d;
            mode_q    <= mode_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            perr_q    <= perr_d;
            setup_q   <= setup_d;
            cpu_q     <= cpu_d;
        end
    end

    assign bus.prdata    = prdata_q;
    assign bus.pready    = pready_q;
    assign bus.perr      = perr_q;
    assign cpu_interrupt = cpu_q;
endmodule

// File: tb/tb_apb_irq_ctrl.sv
// Directed bench for apb_irq_ctrl: register vector table plus hand sequences for
// interrupt timing, level/edge/NMI behaviour, held-enable handshake and async reset.
module tb_apb_irq_ctrl;
    localparam logic [31:0] BASE = 32'h2000_0000;

    logic        pclk = 1'b0;
    logic        presetn = 1'b0;
    logic [15:0] irq_in = '0;
    logic        nmi_in = 1'b0;
    logic        cpu_interrupt;
    int unsigned checks = 0;
    int unsigned errors = 0;

    apb_irq_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    apb_irq_ctrl #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .NUM_IRQ   (16),
        .BASE_ADDR (BASE)
    ) dut (
        .pclk         (pclk),
        .presetn      (presetn),
        .bus          (bus),
        .irq_in       (irq_in),
        .nmi_in       (nmi_in),
        .cpu_interrupt(cpu_interrupt)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [31:0] rdata, output logic err);
        int unsigned n;
        @(negedge pclk);
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        bus.pwrite  = wr;
        bus.paddr   = addr;
        bus.pdata   = data;
        bus.pstb    = strb;
        @(negedge pclk);
        bus.penable = 1'b1;
        n = 0;
        do begin
            @(negedge pclk);
            n++;
        end while (!bus.pready && n < 8);
        if (!bus.pready) begin
            checks++;
            errors++;
            $display("FAIL pready_timeout: addr 0x%08h got pready 0 expected 1", addr);
        end
        rdata = bus.prdata;
        err   = bus.perr;
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
    endtask

    task automatic rd(input logic [31:0] off, input logic [31:0] exp, input string name);
        logic [31:0] d;
        logic        e;
        apb_xfer(1'b0, BASE + off, '0, 4'h0, d, e);
        check({name, "_data"}, d, exp);
        check({name, "_perr"}, 32'(e), 32'd0);
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] data, input logic [3:0] strb);
        logic [31:0] d;
        logic        e;
        apb_xfer(1'b1, BASE + off, data, strb, d, e);
        check("write_perr", 32'(e), 32'd0);
    endtask

    task automatic cycles(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) @(negedge pclk);
    endtask

    initial begin
        logic [31:0] d;
        logic        e;
        logic        seen;

        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
        bus.paddr = '0;  bus.pdata = '0;     bus.pstb = '0;

        // {wr, addr, data, strb, chk_rd, exp_rd, exp_err}
        vecs.push_back('{1'b0, BASE + 32'h00, 32'h0,         4'h0, 1'b1, 32'h0,         1'b0});
        vecs.push_back('{1'b0, BASE + 32'h04, 32'h0,         4'h0, 1'b1, 32'h0,         1'b0});
        vecs.push_back('{1'b0, BASE + 32'h08, 32'h0,         4'h0, 1'b1, 32'h0,         1'b0});
        vecs.push_back('{1'b0, BASE + 32'h0C, 32'h0,         4'h0, 1'b1, 32'h0,         1'b0});
        vecs.push_back('{1'b0, BASE + 32'h10, 32'h0,         4'h0, 1'b1, 32'h0,         1'b0});
        vecs.push_back('{1'b0, BASE + 32'h14, 32'h0,         4'h0, 1'b1, 32'h0,         1'b1});
        vecs.push_back('{1'b1, BASE + 32'h04, 32'h0000FFFF,  4'h1, 1'b0, 32'h0,         1'b0});
        vecs.push_back('{1'b0, BASE + 32'h04, 32'h0,         4'h0, 1'b1, 32'h000000FF,  1'b0});
        vecs.push_back('{1'b1, BASE + 32'h04, 32'h0000ABCD,  4'h0, 1'b0, 32'h0,         1'b0});
        vecs.push_back('{1'b0, BASE + 32'h04, 32'h0,         4'h0, 1'b1, 32'h000000FF,  1'b0});
        vecs.push_back('{1'b1, BASE + 32'h04, 32'hFFFFFFFF,  4'hF, 1'b0, 32'h0,         1'b0});
        vecs.push_back('{1'b0, BASE + 32'h04, 32'h0,         4'h0, 1'b1, 32'h0000FFFF,  1'b0});
        vecs.push_back('{1'b1, BASE + 32'h04, 32'h00001234,  4'h2, 1'b0, 32'h0,         1'b0});
        vecs.push_back('{1'b0, BASE + 32'h04, 32'h0,         4'h0, 1'b1, 32'h000012FF,  1'b0});
        vecs.push_back('{1'b1, BASE + 32'h0C, 32'h00000001,  4'hF, 1'b1, 32'h0,         1'b1});
        vecs.push_back('{1'b1, BASE + 32'h10, 32'h00000001,  4'hF, 1'b1, 32'h0,         1'b1});
        vecs.push_back('{1'b1, BASE + 32'h1C, 32'h0000FFFF,  4'hF, 1'b1, 32'h0,         1'b1});
        vecs.push_back('{1'b1, BASE + 32'h02, 32'h0000FFFF,  4'hF, 1'b1, 32'h0,         1'b1});
        vecs.push_back('{1'b0, BASE + 32'h100, 32'h0,        4'h0, 1'b1, 32'h0,         1'b1});
        vecs.push_back('{1'b0, 32'h1000_0004, 32'h0,         4'h0, 1'b1, 32'h0,         1'b1});
        vecs.push_back('{1'b0, BASE + 32'h04, 32'h0,         4'h0, 1'b1, 32'h000012FF,  1'b0});
        vecs.push_back('{1'b1, BASE + 32'h08, 32'h000F00F0,  4'hF, 1'b0, 32'h0,         1'b0});
        vecs.push_back('{1'b0, BASE + 32'h08, 32'h0,         4'h0, 1'b1, 32'h000000F0,  1'b0});
        vecs.push_back('{1'b1, BASE + 32'h08, 32'h0,         4'hF, 1'b0, 32'h0,         1'b0});
        vecs.push_back('{1'b1, BASE + 32'h04, 32'h0,         4'hF, 1'b0, 32'h0,         1'b0});
        vecs.push_back('{1'b0, BASE + 32'h04, 32'h0,         4'h0, 1'b1, 32'h0,         1'b0});
        vecs.push_back('{1'b0, BASE + 32'h00, 32'h0,         4'h0, 1'b1, 32'h0,         1'b0});

        cycles(3);
        presetn = 1'b1;
        cycles(2);
        check("reset_cpu_interrupt", 32'(cpu_interrupt), 32'd0);
        check("reset_pready", 32'(bus.pready), 32'd0);
        check("reset_perr", 32'(bus.perr), 32'd0);
        check("reset_prdata", bus.prdata, 32'd0);

        foreach (vecs[i]) begin
            apb_xfer(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].strb, d, e);
            check($sformatf("vec%0d_perr", i), 32'(e), 32'(vecs[i].exp_err));
            if (vecs[i].chk_rd) check($sformatf("vec%0d_prdata", i), d, vecs[i].exp_rd);
        end

        // penable held past completion: exactly one pready pulse
        @(negedge pclk);
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = BASE + 32'h04;
        @(negedge pclk);
        bus.penable = 1'b1;
        @(negedge pclk);
        check("held_pready_first", 32'(bus.pready), 32'd1);
        @(negedge pclk);
        check("held_pready_second", 32'(bus.pready), 32'd0);
        @(negedge pclk);
        check("held_pready_third", 32'(bus.pready), 32'd0);
        bus.psel = 1'b0; bus.penable = 1'b0;

        // Edge source 0: pending at +3 edges, cpu_interrupt at +4, W1C clears
        wr(32'h04, 32'h1, 4'hF);
        wr(32'h08, 32'h1, 4'hF);
        irq_in[0] = 1'b1;
        @(negedge pclk);
        irq_in[0] = 1'b0;
        cycles(2);
        check("edge_cpu_at_3", 32'(cpu_interrupt), 32'd0);
        @(negedge pclk);
        check("edge_cpu_at_4", 32'(cpu_interrupt), 32'd1);
        rd(32'h00, 32'h1, "edge_pending");
        rd(32'h0C, 32'h8000_0000, "edge_claim");
        wr(32'h00, 32'h1, 4'hF);
        check("w1c_cpu_same", 32'(cpu_interrupt), 32'd1);
        @(negedge pclk);
        check("w1c_cpu_next", 32'(cpu_interrupt), 32'd0);
        rd(32'h00, 32'h0, "w1c_pending");

        // Level sources 2 and 3
        wr(32'h08, 32'h0, 4'hF);
        wr(32'h04, 32'h0C, 4'hF);
        irq_in = 16'h000C;
        cycles(5);
        rd(32'h0C, 32'h8000_0002, "level_claim_both");
        check("level_cpu", 32'(cpu_interrupt), 32'd1);
        rd(32'h10, 32'h0000_000C, "level_raw");
        wr(32'h00, 32'h0C, 4'hF);
        rd(32'h00, 32'h0000_000C, "level_w1c_ignored");
        irq_in = 16'h0008;
        cycles(5);
        rd(32'h0C, 32'h8000_0003, "level_claim_3");
        irq_in = 16'h0000;
        cycles(5);
        rd(32'h0C, 32'h0, "level_claim_none");
        check("level_cpu_off", 32'(cpu_interrupt), 32'd0);

        // Switching a pending level bit to edge mode drops it
        irq_in = 16'h0002;
        cycles(5);
        rd(32'h00, 32'h2, "mode_pre_pending");
        wr(32'h08, 32'h2, 4'hF);
        rd(32'h00, 32'h0, "mode_switch_clears");
        irq_in = 16'h0000;

        // NMI: sticky, unmasked, set beats W1C
        wr(32'h04, 32'h0, 4'hF);
        nmi_in = 1'b1;
        @(negedge pclk);
        nmi_in = 1'b0;
        cycles(4);
        rd(32'h00, 32'h8000_0000, "nmi_pending");
        check("nmi_cpu", 32'(cpu_interrupt), 32'd1);
        rd(32'h0C, 32'h0, "nmi_claim");
        wr(32'h00, 32'h8000_0000, 4'hF);
        rd(32'h00, 32'h0, "nmi_w1c");
        nmi_in = 1'b1;
        cycles(4);
        wr(32'h00, 32'h8000_0000, 4'hF);
        rd(32'h00, 32'h8000_0000, "nmi_set_wins");
        nmi_in = 1'b0;
        cycles(4);
        wr(32'h00, 32'h8000_0000, 4'hF);
        cycles(2);
        check("nmi_cpu_off", 32'(cpu_interrupt), 32'd0);

        // Async reset while pready is high and the access is still held
        wr(32'h08, 32'h1, 4'hF);
        wr(32'h04, 32'h1, 4'hF);
        irq_in[0] = 1'b1;
        @(negedge pclk);
        irq_in[0] = 1'b0;
        cycles(5);
        check("prereset_cpu", 32'(cpu_interrupt), 32'd1);
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = BASE + 32'h04;
        @(negedge pclk);
        bus.penable = 1'b1;
        @(negedge pclk);
        check("prereset_pready", 32'(bus.pready), 32'd1);
        check("prereset_prdata", bus.prdata, 32'h1);
        #1 presetn = 1'b0;
        #1;
        check("async_pready", 32'(bus.pready), 32'd0);
        check("async_cpu", 32'(cpu_interrupt), 32'd0);
        check("async_prdata", bus.prdata, 32'd0);
        cycles(2);
        presetn = 1'b1;
        seen = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            @(negedge pclk);
            if (bus.pready) seen = 1'b1;
        end
        check("postreset_no_pready", 32'(seen), 32'd0);
        bus.psel = 1'b0; bus.penable = 1'b0;
        rd(32'h04, 32'h0, "postreset_mask");
        rd(32'h08, 32'h0, "postreset_mode");
        rd(32'h00, 32'h0, "postreset_pending");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
